// File: rtl/f1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : f1_pkg
//  Description : Shared types and default sizes for the F1 start-lights
//                sequencer: state encoding and default parameter values.
//  Revision    : 1.0  - initial release
// ============================================================================
package f1_pkg;

    // Default number of lights and width of the random delay word.
    localparam int F1_N_LIGHTS   = 8;
    localparam int F1_DATA_WIDTH = 7;

    // Sequencer states: idle, lights filling in, random hold before lights-out.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEQ  = 2'd1,
        WAIT = 2'd2
    } f1_state_e;

endpackage : f1_pkg
`default_nettype wire

// File: rtl/f1_lights_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : f1_lights_sequencer
//  Description : Formula-1 style start-lights sequencer. On a trigger it
//                captures a random delay from an external LFSR, lights the
//                outputs one by one on each tick, holds all lights for the
//                captured number of ticks, then turns them off with a
//                one-cycle done pulse.
//  Ports       : clk       - rising-edge clock
//                rst       - asynchronous active-low reset
//                trigger   - start request, sampled while idle
//                abort     - cancel a running sequence (no done pulse)
//                tick      - timebase strobe; every step advances on tick
//                lfsr_data - random delay word from the external LFSR
//                lfsr_en   - LFSR advance enable (high only while idle)
//                lights    - light drive, bit 0 lit first
//                busy      - high whenever a sequence is running
//                done      - one-cycle pulse when the lights go out
//  Revision    : 1.0  - initial release
// ============================================================================
module f1_lights_sequencer
    import f1_pkg::*;
#(
    parameter int N_LIGHTS   = F1_N_LIGHTS,
    parameter int DATA_WIDTH = F1_DATA_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trigger,
    input  logic                abort,
    input  logic                tick,
    input  logic [DATA_WIDTH:1] lfsr_data,
    output logic                lfsr_en,
    output logic [N_LIGHTS-1:0] lights,
    output logic                busy,
    output logic                done
);

    f1_state_e               state_q,  state_d;
    logic [N_LIGHTS-1:0]     lights_q, lights_d;
    logic [DATA_WIDTH-1:0]   delay_q,  delay_d;
    logic [DATA_WIDTH-1:0]   cnt_q,    cnt_d;
    logic                    done_q,   done_d;

    // Next light pattern: shift left with a 1 fed into bit 0. Written as a
    // shift/or so it stays legal for a single-light build.
    logic [N_LIGHTS-1:0]     w_shift;
    assign w_shift = (lights_q << 1) | N_LIGHTS'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            lights_q <= '0;
            delay_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lights_q <= lights_d;
            delay_q  <= delay_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lights_d = lights_q;
        delay_d  = delay_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                lights_d = '0;
                // Abort alongside trigger keeps the block idle. A tick in
                // the accept cycle is deliberately not acted on.
                if (trigger && !abort) begin
                    // A zero delay word is clamped to 1 so the hold phase
                    // always lasts at least one tick.
                    delay_d = (lfsr_data == '0) ? DATA_WIDTH'(1) : lfsr_data;
                    state_d = SEQ;
                end
            end

            SEQ: begin
                if (abort) begin
                    state_d  = IDLE;
                    lights_d = '0;
                end else if (tick) begin
                    lights_d = w_shift;
                    // Enter the hold phase on the same edge the last light
                    // comes on.
                    if (&w_shift) begin
                        state_d = WAIT;
                        cnt_d   = delay_q;
                    end
                end
            end

            WAIT: begin
                if (abort) begin
                    state_d  = IDLE;
                    lights_d = '0;
                end else if (tick) begin
                    if (cnt_q == DATA_WIDTH'(1)) begin
                        lights_d = '0;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q - DATA_WIDTH'(1);
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                lights_d = '0;
            end
        endcase
    end

    assign lights  = lights_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);
    assign lfsr_en = (state_q == IDLE);

endmodule : f1_lights_sequencer
`default_nettype wire
